// File: rtl/mem_initiator.sv
// mem_initiator: bus-master sequencer for the Neander 4x8 data memory.
// Turns single or burst read/write requests into registered memory strobes.
// Each beat spends one SETUP cycle, where the address settles, and one
// ACCESS cycle, where the strobe fires. A DONE cycle closes each request.
module mem_initiator #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              op_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] mem_end,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic                op_r, op_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                busy_r, busy_s;
  logic                rvalid_r, rvalid_s;
  logic [DATA_W-1:0]   rdata_r, rdata_s;
  logic                done_r, done_s;
  logic [ADDR_W-1:0]   mem_end_r, mem_end_s;
  logic                mem_write_r, mem_write_s;
  logic                mem_read_r, mem_read_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;

  // State register; reset aborts any request in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request context and registered outputs, loaded with the values for the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r      <= ADDR_ZERO;
      cnt_r       <= ADDR_ZERO;
      op_r        <= 1'b0;
      wdata_r     <= DATA_ZERO;
      busy_r      <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= DATA_ZERO;
      done_r      <= 1'b0;
      mem_end_r   <= ADDR_ZERO;
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_wdata_r <= DATA_ZERO;
    end else begin
      addr_r      <= addr_s;
      cnt_r       <= cnt_s;
      op_r        <= op_s;
      wdata_r     <= wdata_s;
      busy_r      <= busy_s;
      rvalid_r    <= rvalid_s;
      rdata_r     <= rdata_s;
      done_r      <= done_s;
      mem_end_r   <= mem_end_s;
      mem_write_r <= mem_write_s;
      mem_read_r  <= mem_read_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  // Next-state and next-output logic; pulses default low, context defaults to hold.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    cnt_s       = cnt_r;
    op_s        = op_r;
    wdata_s     = wdata_r;
    busy_s      = busy_r;
    rvalid_s    = 1'b0;
    rdata_s     = rdata_r;
    done_s      = 1'b0;
    mem_end_s   = mem_end_r;
    mem_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          // Capture the whole request; later input changes are ignored.
          state_s     = SETUP;
          op_s        = op_wr;
          addr_s      = addr;
          cnt_s       = len;
          wdata_s     = wdata;
          busy_s      = 1'b1;
          mem_end_s   = addr;
          mem_wdata_s = wdata;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      SETUP: begin
        // Address has now been stable a full cycle; fire exactly one strobe.
        state_s     = ACCESS;
        mem_write_s = op_r;
        mem_read_s  = ~op_r;
      end
      ACCESS: begin
        if (op_r) begin
          rdata_s  = rdata_r;
          rvalid_s = 1'b0;
        end else begin
          rdata_s  = mem_rdata;
          rvalid_s = 1'b1;
        end
        if (cnt_r == ADDR_ZERO) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          // Address wraps naturally at the top of the address space.
          state_s   = SETUP;
          addr_s    = addr_r + ADDR_ONE;
          cnt_s     = cnt_r - ADDR_ONE;
          mem_end_s = addr_r + ADDR_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_r;
  assign rvalid    = rvalid_r;
  assign rdata     = rdata_r;
  assign done      = done_r;
  assign mem_end   = mem_end_r;
  assign mem_write = mem_write_r;
  assign mem_read  = mem_read_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: a behavioural memory on the bus side
// and a reference model that expands each accepted request into the expected
// per-cycle bus trace (2 cycles per beat plus a closing cycle).
module tb_mem_initiator;

  logic       clock;
  logic       reset;
  logic       req;
  logic       op_wr;
  logic [1:0] addr;
  logic [1:0] len;
  logic [7:0] wdata;
  logic       busy;
  logic       rvalid;
  logic [7:0] rdata;
  logic       done;
  logic [1:0] mem_end;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks;
  int failures;
  int busy_seen;

  typedef struct {
    logic       busy;
    logic [1:0] mend;
    logic       mw;
    logic       mr;
    logic [7:0] mwd;
    logic       rv;
    logic [7:0] rd;
    logic       dn;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] tbmem[4];
  logic [7:0] ref_mem[4];
  logic [1:0] last_end;
  logic [7:0] last_wdata;
  logic [7:0] last_rdata;
  logic       was_idle;

  mem_initiator #(.ADDR_W(2), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .op_wr(op_wr), .addr(addr),
    .len(len), .wdata(wdata), .busy(busy), .rvalid(rvalid), .rdata(rdata),
    .done(done), .mem_end(mem_end), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Bus-side memory: stores on the edge closing a write strobe, read output gated.
  always @(posedge clock) begin
    if (mem_write) tbmem[mem_end] <= mem_wdata;
  end
  assign mem_rdata = mem_read ? tbmem[mem_end] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expand one request into its expected cycle-by-cycle trace.
  task automatic build(input logic o, input logic [1:0] a, input logic [1:0] l, input logic [7:0] d);
    rec_t r;
    logic [1:0] ad;
    int n;
    n = int'(l) + 1;
    ad = a;
    for (int i = 0; i < n; i++) begin
      ad = 2'((int'(a) + i) % 4);
      r = '{busy:1'b1, mend:ad, mw:1'b0, mr:1'b0, mwd:d, rv:(i > 0) && !o, rd:last_rdata, dn:1'b0};
      exp_q.push_back(r);
      r = '{busy:1'b1, mend:ad, mw:o, mr:!o, mwd:d, rv:1'b0, rd:last_rdata, dn:1'b0};
      exp_q.push_back(r);
      if (o) ref_mem[ad] = d;
      else   last_rdata = ref_mem[ad];
    end
    r = '{busy:1'b1, mend:ad, mw:1'b0, mr:1'b0, mwd:d, rv:!o, rd:last_rdata, dn:1'b1};
    exp_q.push_back(r);
    last_end = ad;
    last_wdata = d;
  endtask

  task automatic compare_now();
    rec_t e;
    if (exp_q.size() == 0) begin
      was_idle = 1'b1;
      e = '{busy:1'b0, mend:last_end, mw:1'b0, mr:1'b0, mwd:last_wdata, rv:1'b0, rd:last_rdata, dn:1'b0};
    end else begin
      was_idle = 1'b0;
      e = exp_q.pop_front();
    end
    if (busy === 1'b1) busy_seen++;
    check("busy",      32'(busy),      32'(e.busy));
    check("mem_end",   32'(mem_end),   32'(e.mend));
    check("mem_write", 32'(mem_write), 32'(e.mw));
    check("mem_read",  32'(mem_read),  32'(e.mr));
    check("mem_wdata", 32'(mem_wdata), 32'(e.mwd));
    check("rvalid",    32'(rvalid),    32'(e.rv));
    check("rdata",     32'(rdata),     32'(e.rd));
    check("done",      32'(done),      32'(e.dn));
  endtask

  // One clock cycle: check current outputs, then drive inputs for the next edge.
  task automatic cycle(input logic r, input logic o, input logic [1:0] a, input logic [1:0] l, input logic [7:0] d);
    @(negedge clock);
    compare_now();
    req = r; op_wr = o; addr = a; len = l; wdata = d;
    if (was_idle && r) build(o, a, l, d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'(($urandom)), 2'($urandom), 2'($urandom), 8'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_rvalid"}, 32'(rvalid),    32'd0);
    check({tag, "_done"},   32'(done),      32'd0);
    check({tag, "_mw"},     32'(mem_write), 32'd0);
    check({tag, "_mr"},     32'(mem_read),  32'd0);
    check({tag, "_rdata"},  32'(rdata),     32'd0);
    check({tag, "_mend"},   32'(mem_end),   32'd0);
    check({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // Asynchronous reset mid-cycle: outputs clear at once and the request is dropped.
  task automatic reset_pulse();
    reset = 1'b0;
    req = 1'b0;
    #1;
    check_all_zero("rst_async");
    exp_q.delete();
    last_end = 2'd0;
    last_wdata = 8'h00;
    last_rdata = 8'h00;
    @(negedge clock);
    check_all_zero("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; busy_seen = 0;
    clock = 1'b0; reset = 1'b0;
    req = 1'b0; op_wr = 1'b0; addr = 2'd0; len = 2'd0; wdata = 8'h00;
    last_end = 2'd0; last_wdata = 8'h00; last_rdata = 8'h00; was_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tbmem[i] = 8'($urandom);
      ref_mem[i] = tbmem[i];
    end
    #3;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    idle_cycles(2);

    // Single write then read of the same word.
    cycle(1'b1, 1'b1, 2'd2, 2'd0, 8'hA5);
    idle_cycles(4);
    cycle(1'b1, 1'b0, 2'd2, 2'd0, 8'h00);
    idle_cycles(4);
    check("rw_rdata", 32'(rdata), 32'hA5);

    // Read burst wrapping 3 -> 0 -> 1 after preloading those words.
    cycle(1'b1, 1'b1, 2'd3, 2'd0, 8'h11); idle_cycles(3);
    cycle(1'b1, 1'b1, 2'd0, 2'd0, 8'h22); idle_cycles(3);
    cycle(1'b1, 1'b1, 2'd1, 2'd0, 8'h33); idle_cycles(3);
    busy_seen = 0;
    cycle(1'b1, 1'b0, 2'd3, 2'd2, 8'h00);
    idle_cycles(9);
    check("burst_busy_cycles", 32'(busy_seen), 32'd7);
    check("burst_last_rdata",  32'(rdata),     32'h33);

    // Fill burst of zeros, then read everything back.
    cycle(1'b1, 1'b1, 2'd0, 2'd3, 8'h00);
    idle_cycles(10);
    cycle(1'b1, 1'b0, 2'd0, 2'd3, 8'hFF);
    idle_cycles(10);
    for (int i = 0; i < 4; i++) check("fill_mem", 32'(tbmem[i]), 32'h00);

    // Reset during the second ACCESS of a 4-beat read, then a normal request.
    cycle(1'b1, 1'b0, 2'd1, 2'd3, 8'h00);
    idle_cycles(4);
    reset_pulse();
    idle_cycles(3);
    cycle(1'b1, 1'b1, 2'd1, 2'd1, 8'h5C);
    idle_cycles(6);
    cycle(1'b1, 1'b0, 2'd1, 2'd1, 8'h00);
    idle_cycles(6);
    check("post_reset_rdata", 32'(rdata), 32'h5C);

    // Handshake: req held high with changing inputs; only IDLE accepts.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'(($urandom)), 2'($urandom), 2'($urandom), 8'($urandom));
    idle_cycles(10);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'(($urandom_range(0, 2) == 0)), 1'(($urandom)), 2'($urandom), 2'($urandom), 8'($urandom));
    end
    idle_cycles(12);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) check("final_mem", 32'(tbmem[i]), 32'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
